// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-outstanding data-memory responder with a fixed access
//            latency. Optional misaligned-access detection is enabled by
//            defining DMEM_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int         c_aw  = $clog2(DEPTH);
  localparam logic [3:0] c_lat = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_capture;
  logic              w_access;
  logic              w_misaligned;
  logic              w_mem_we;
  logic              w_unused_addr;
  logic              r_we;
  logic [c_aw-1:0]   r_idx;
  logic [31:0]       r_wd;
  logic [31:0]       r_rd;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_capture   = 1'b1;
          w_cnt_nxt   = c_lat;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_access    = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef DMEM_ALIGN_CHECK_EN
  logic [1:0] r_lo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lo <= 2'b00;
    end else if (w_capture) begin
      r_lo <= a[1:0];
    end
  end

  assign w_misaligned  = (r_lo != 2'b00);
  assign w_unused_addr = ^a[31:c_aw+2];
`else
  assign w_misaligned  = 1'b0;
  assign w_unused_addr = ^{a[31:c_aw+2], a[1:0]};
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_idx   <= '0;
      r_wd    <= 32'd0;
      r_rd    <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_capture) begin
        r_we  <= we;
        r_idx <= a[c_aw+1:2];
        r_wd  <= wd;
      end
      if (w_access) begin
        r_err <= w_misaligned;
        if (!r_we) begin
          r_rd <= w_misaligned ? 32'd0 : r_mem[r_idx];
        end
      end
    end
  end

  // Storage is deliberately not reset; a dropped transaction never writes.
  assign w_mem_we = w_access & r_we & ~w_misaligned;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wd;
    end
  end

  assign rd    = r_rd;
  assign ready = (r_state == S_DONE);
  assign busy  = (r_state != S_IDLE);
  assign err   = ready & r_err;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Purpose  : Directed, table-driven bench for dmem_responder at LATENCY 2, 0, 15.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int c_n = 3;

`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit c_aln = 1'b1;
`else
  localparam bit c_aln = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_s   [c_n];
  logic        we_s    [c_n];
  logic [31:0] a_s     [c_n];
  logic [31:0] wd_s    [c_n];
  logic [31:0] rd_s    [c_n];
  logic        ready_s [c_n];
  logic        busy_s  [c_n];
  logic        err_s   [c_n];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < c_n; g++) begin : g_dut
    dmem_responder #(
      .DEPTH  (64),
      .LATENCY((g == 0) ? 2 : ((g == 1) ? 0 : 15))
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .req   (req_s[g]),
      .we    (we_s[g]),
      .a     (a_s[g]),
      .wd    (wd_s[g]),
      .rd    (rd_s[g]),
      .ready (ready_s[g]),
      .busy  (busy_s[g]),
      .err   (err_s[g])
    );
  end

  typedef struct {
    bit          we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Issues one request on instance d once it is idle; returns the number of
  // edges from the accept edge to the edge that raised ready.
  task automatic txn(input int d, input bit w, input logic [31:0] addr,
                     input logic [31:0] data, output int lat);
    int guard;
    guard = 0;
    while (busy_s[d] && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    req_s[d] = 1'b1;
    we_s[d]  = w;
    a_s[d]   = addr;
    wd_s[d]  = data;
    @(posedge clk);
    #1 req_s[d] = 1'b0;
    a_s[d] = 32'hFFFF_FFFF;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ready_s[d]) break;
    end
    if (!ready_s[d]) begin
      chk("ready_timeout", 32'(ready_s[d]), 32'd1);
    end
  endtask

  // After the ready cycle the next edge must drop ready and return to idle.
  task automatic chk_after(input int d, input string nm);
    @(posedge clk);
    @(negedge clk);
    chk({nm, "_pulse"}, 32'(ready_s[d]), 32'd0);
    chk({nm, "_idle"}, 32'(busy_s[d]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [12];
    logic [31:0] last_rd;
    int          lat;
    int          pulses;
    int          dbl;
    bit          prev;

    vecs[0]  = '{1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b1, 32'h0000_0100, 32'hCAFE_0001, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h0000_0000, 32'h0,         32'hCAFE_0001, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0010, 32'h55AA_55AA, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0,         32'h55AA_55AA, 1'b0};
    vecs[6]  = '{1'b1, 32'h0000_000C, 32'hA5A5_0003, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_010C, 32'h0,         32'hA5A5_0003, 1'b0};
    vecs[8]  = '{1'b1, 32'h0000_0008, 32'h1111_1111, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_000A, 32'hFFFF_FFFF, 32'h0, c_aln};
    vecs[10] = '{1'b0, 32'h0000_0008, 32'h0,
                 c_aln ? 32'h1111_1111 : 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{1'b0, 32'h0000_000B, 32'h0,
                 c_aln ? 32'h0000_0000 : 32'hFFFF_FFFF, c_aln};

    reset = 1'b1;
    for (int i = 0; i < c_n; i++) begin
      req_s[i] = 1'b0;
      we_s[i]  = 1'b0;
      a_s[i]   = 32'd0;
      wd_s[i]  = 32'd0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready_s[0]), 32'd0);
    chk("rst_busy",  32'(busy_s[0]),  32'd0);
    chk("rst_rd",    rd_s[0],         32'd0);
    chk("rst_err",   32'(err_s[0]),   32'd0);
    reset = 1'b0;
    @(negedge clk);

    last_rd = 32'd0;
    for (int i = 0; i < 12; i++) begin
      txn(0, vecs[i].we, vecs[i].a, vecs[i].wd, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      if (!vecs[i].we) last_rd = vecs[i].exp_rd;
      chk($sformatf("v%0d_rd", i), rd_s[0], last_rd);
      chk($sformatf("v%0d_err", i), 32'(err_s[0]), 32'(vecs[i].exp_err));
      chk_after(0, $sformatf("v%0d", i));
      chk($sformatf("v%0d_rdhold", i), rd_s[0], last_rd);
    end

    // Continuous req: address only stays 0x08 while idle, so WAIT-phase
    // changes must not leak into the returned data.
    txn(0, 1'b1, 32'h0000_0008, 32'h0BAD_F00D, lat);
    chk_after(0, "pre_hold");
    pulses = 0;
    dbl    = 0;
    prev   = 1'b0;
    req_s[0] = 1'b1;
    we_s[0]  = 1'b0;
    a_s[0]   = 32'h0000_0008;
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ready_s[0]) begin
        pulses++;
        chk($sformatf("hold_rd%0d", pulses), rd_s[0], 32'h0BAD_F00D);
        if (prev) dbl++;
      end
      prev = ready_s[0];
      a_s[0] = busy_s[0] ? 32'h0000_0004 : 32'h0000_0008;
      if (i == 10) req_s[0] = 1'b0;
    end
    chk("hold_pulses", 32'(pulses), 32'd3);
    chk("hold_single", 32'(dbl), 32'd0);

    // Reset in the middle of a write must drop it.
    req_s[0] = 1'b1;
    we_s[0]  = 1'b1;
    a_s[0]   = 32'h0000_0010;
    wd_s[0]  = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy_s[0]), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", 32'(ready_s[0]), 32'd0);
    chk("mid_rst_busy",  32'(busy_s[0]),  32'd0);
    chk("mid_rst_rd",    rd_s[0],         32'd0);
    chk("mid_rst_err",   32'(err_s[0]),   32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    txn(0, 1'b0, 32'h0000_0010, 32'h0, lat);
    chk("post_rst_rd", rd_s[0], 32'h55AA_55AA);
    chk_after(0, "post_rst");

    // LATENCY 0 and LATENCY 15 instances.
    txn(1, 1'b1, 32'h0000_0020, 32'h0000_00A0, lat);
    chk("l0_wr_lat", 32'(lat), 32'd1);
    chk_after(1, "l0_wr");
    txn(1, 1'b0, 32'h0000_0020, 32'h0, lat);
    chk("l0_rd_lat", 32'(lat), 32'd1);
    chk("l0_rd", rd_s[1], 32'h0000_00A0);
    chk_after(1, "l0_rd");
    txn(2, 1'b1, 32'h0000_003C, 32'hF00D_0015, lat);
    chk("l15_wr_lat", 32'(lat), 32'd16);
    chk_after(2, "l15_wr");
    txn(2, 1'b0, 32'h0000_003C, 32'h0, lat);
    chk("l15_rd_lat", 32'(lat), 32'd16);
    chk("l15_rd", rd_s[2], 32'hF00D_0015);
    chk_after(2, "l15_rd");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
